// File: rtl/rf_wr_arb.sv
// Register-file write / dirty-clear port arbiter between the WB stage (always granted)
// and a FIFO-buffered MUL/DIV result stream, with starvation-driven WB stall.
module rf_wr_arb #(
   parameter int TAG_WIDTH    = 4,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_wr_en,
   input  logic                 wb_clr_en,
   input  logic [TAG_WIDTH-1:0] wb_wr_tag,
   input  logic [4:0]           wb_wr_addr,
   input  logic [31:0]          wb_wr_data,
   output logic                 stall_wb,
   input  logic                 mdu_valid,
   output logic                 mdu_ready,
   input  logic [TAG_WIDTH-1:0] mdu_tag,
   input  logic [4:0]           mdu_addr,
   input  logic [31:0]          mdu_data,
   input  logic                 mdu_flush,
   output logic                 rf_wr_en,
   output logic [TAG_WIDTH-1:0] rf_wr_tag,
   output logic [4:0]           rf_wr_addr,
   output logic [31:0]          rf_wr_data,
   output logic                 clr_dirty_en,
   output logic [4:0]           clr_dirty_addr
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
   logic [4:0]           addr_q [DEPTH];
   logic [31:0]          data_q [DEPTH];
   logic [DEPTH-1:0]     killed_q;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [WAIT_W-1:0] wait_cnt;

   logic head_vld, head_killed, push, pop_live, pop_kill, pop;

   logic                 wr_vld_p0;
   logic [TAG_WIDTH-1:0] wr_tag_p0;
   logic [4:0]           wr_addr_p0;
   logic [31:0]          wr_data_p0;
   logic                 clr_vld_p0;
   logic [4:0]           clr_addr_p0;

   // p0: arbitration; killed state is read before this cycle's flush lands
   assign mdu_ready   = (cnt != FULL_CNT);
   assign stall_wb    = (wait_cnt == WAIT_MAX);
   assign head_vld    = (cnt != '0);
   assign head_killed = killed_q[rd_ptr];
   assign push        = mdu_valid & mdu_ready;
   assign pop_live    = head_vld & ~head_killed & ~wb_wr_en;
   assign pop_kill    = head_vld &  head_killed & ~wb_clr_en;
   assign pop         = pop_live | pop_kill;

   always_comb begin
      wr_vld_p0   = wb_wr_en | pop_live;
      wr_tag_p0   = '0;
      wr_addr_p0  = '0;
      wr_data_p0  = '0;
      clr_vld_p0  = wb_clr_en | pop_kill;
      clr_addr_p0 = '0;
      if (wb_wr_en) begin
         wr_tag_p0  = wb_wr_tag;
         wr_addr_p0 = wb_wr_addr;
         wr_data_p0 = wb_wr_data;
      end else if (pop_live) begin
         wr_tag_p0  = tag_q[rd_ptr];
         wr_addr_p0 = addr_q[rd_ptr];
         wr_data_p0 = data_q[rd_ptr];
      end
      if (wb_clr_en)
         clr_addr_p0 = wb_wr_addr;
      else if (pop_kill)
         clr_addr_p0 = addr_q[rd_ptr];
   end

   // FIFO storage: validity is carried by the pointers, so entries need no reset
   always_ff @(posedge clk) begin
      if (mdu_flush)
         killed_q <= '1;
      if (push) begin
         tag_q[wr_ptr]    <= mdu_tag;
         addr_q[wr_ptr]   <= mdu_addr;
         data_q[wr_ptr]   <= mdu_data;
         killed_q[wr_ptr] <= mdu_flush;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         wait_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (!head_vld || pop)
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // p1: registered port outputs, zero whenever the port had no grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wr_en       <= 1'b0;
         rf_wr_tag      <= '0;
         rf_wr_addr     <= '0;
         rf_wr_data     <= '0;
         clr_dirty_en   <= 1'b0;
         clr_dirty_addr <= '0;
      end else begin
         rf_wr_en       <= wr_vld_p0;
         rf_wr_tag      <= wr_tag_p0;
         rf_wr_addr     <= wr_addr_p0;
         rf_wr_data     <= wr_data_p0;
         clr_dirty_en   <= clr_vld_p0;
         clr_dirty_addr <= clr_addr_p0;
      end
   end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: A priority, B buffering, flush-to-clear,
// starvation stall and mid-operation reset.
module tb_rf_wr_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_wr_en, wb_clr_en;
   logic [3:0]  wb_wr_tag;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        stall_wb;
   logic        mdu_valid, mdu_ready;
   logic [3:0]  mdu_tag;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        mdu_flush;
   logic        rf_wr_en;
   logic [3:0]  rf_wr_tag;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        clr_dirty_en;
   logic [4:0]  clr_dirty_addr;

   int n_vec = 0;
   int n_err = 0;

   rf_wr_arb #(.TAG_WIDTH(4), .DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .wb_wr_en(wb_wr_en), .wb_clr_en(wb_clr_en), .wb_wr_tag(wb_wr_tag),
      .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .stall_wb(stall_wb),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_tag(mdu_tag),
      .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_flush(mdu_flush),
      .rf_wr_en(rf_wr_en), .rf_wr_tag(rf_wr_tag), .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data), .clr_dirty_en(clr_dirty_en),
      .clr_dirty_addr(clr_dirty_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset !== 1'b1)
         assert (!(wb_wr_en === 1'b1 && wb_clr_en === 1'b1))
            else $error("illegal stimulus: wb_wr_en and wb_clr_en both high");

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_wr_en = 0; wb_clr_en = 0; wb_wr_tag = 0; wb_wr_addr = 0; wb_wr_data = 0;
      mdu_valid = 0; mdu_tag = 0; mdu_addr = 0; mdu_data = 0; mdu_flush = 0;
   endtask

   task automatic a_wr(input logic [4:0] a, input logic [31:0] d);
      wb_clr_en = 0; wb_wr_en = 1; wb_wr_tag = 4'hF; wb_wr_addr = a; wb_wr_data = d;
   endtask

   task automatic b_push(input logic [3:0] t, input logic [4:0] a, input logic [31:0] d);
      mdu_valid = 1; mdu_tag = t; mdu_addr = a; mdu_data = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_rf_wr_en got %b exp 0", rf_wr_en); end
      n_vec++; if (rf_wr_data !== 32'h0) begin n_err++; $display("FAIL rst_rf_wr_data got %h exp 0", rf_wr_data); end
      n_vec++; if (clr_dirty_en !== 1'b0) begin n_err++; $display("FAIL rst_clr_en got %b exp 0", clr_dirty_en); end
      n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL rst_mdu_ready got %b exp 1", mdu_ready); end
      n_vec++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall_wb); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_a_write();
      idle();
      wb_wr_en = 1; wb_wr_addr = 5'd5; wb_wr_data = 32'h1234; wb_wr_tag = 4'd3;
      tick();
      idle();
      n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL a_wr_en got %b exp 1", rf_wr_en); end
      n_vec++; if (rf_wr_addr !== 5'd5) begin n_err++; $display("FAIL a_wr_addr got %0d exp 5", rf_wr_addr); end
      n_vec++; if (rf_wr_data !== 32'h1234) begin n_err++; $display("FAIL a_wr_data got %h exp 1234", rf_wr_data); end
      n_vec++; if (rf_wr_tag !== 4'd3) begin n_err++; $display("FAIL a_wr_tag got %0d exp 3", rf_wr_tag); end
      n_vec++; if (clr_dirty_en !== 1'b0) begin n_err++; $display("FAIL a_wr_clr got %b exp 0", clr_dirty_en); end
      tick();
      n_vec++; if (rf_wr_en !== 1'b0 || rf_wr_data !== 32'h0) begin n_err++; $display("FAIL a_wr_idle got en=%b data=%h exp 0/0", rf_wr_en, rf_wr_data); end
   endtask

   task automatic test_b_only();
      idle();
      b_push(4'd1, 5'd7, 32'hAA);
      n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL b_ready_pre got %b exp 1", mdu_ready); end
      tick();
      idle();
      n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL b_early got %b exp 0", rf_wr_en); end
      n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL b_ready_post got %b exp 1", mdu_ready); end
      tick();
      n_vec++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hAA || rf_wr_tag !== 4'd1)
         begin n_err++; $display("FAIL b_write got en=%b addr=%0d data=%h tag=%0d exp 1/7/aa/1", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_tag); end
      tick();
      n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL b_once got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_starve();
      idle();
      a_wr(5'd1, 32'hA0); b_push(4'd2, 5'd10, 32'h100);
      tick();
      a_wr(5'd1, 32'hA1); b_push(4'd4, 5'd11, 32'h200);
      n_vec++; if (rf_wr_data !== 32'hA0) begin n_err++; $display("FAIL st_a0 got %h exp a0", rf_wr_data); end
      tick();
      mdu_valid = 0;
      n_vec++; if (mdu_ready !== 1'b0) begin n_err++; $display("FAIL st_full got %b exp 0", mdu_ready); end
      for (int i = 0; i < 3; i++) begin
         a_wr(5'd1, 32'hA2 + i);
         n_vec++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL st_early_stall%0d got %b exp 0", i, stall_wb); end
         tick();
      end
      n_vec++; if (stall_wb !== 1'b1) begin n_err++; $display("FAIL st_stall_rise got %b exp 1", stall_wb); end
      a_wr(5'd1, 32'hA5);
      tick();
      wb_wr_en = 0;
      n_vec++; if (stall_wb !== 1'b1) begin n_err++; $display("FAIL st_stall_hold got %b exp 1", stall_wb); end
      n_vec++; if (rf_wr_data !== 32'hA5) begin n_err++; $display("FAIL st_a_wins got %h exp a5", rf_wr_data); end
      tick();
      n_vec++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10 || rf_wr_data !== 32'h100 || rf_wr_tag !== 4'd2)
         begin n_err++; $display("FAIL st_head0 got en=%b addr=%0d data=%h tag=%0d exp 1/10/100/2", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_tag); end
      n_vec++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL st_ready_back got %b exp 1", mdu_ready); end
      for (int i = 0; i < 4; i++) begin
         a_wr(5'd1, 32'hB0 + i);
         n_vec++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL st_restart%0d got %b exp 0", i, stall_wb); end
         tick();
      end
      n_vec++; if (stall_wb !== 1'b1) begin n_err++; $display("FAIL st_stall2 got %b exp 1", stall_wb); end
      idle();
      tick();
      n_vec++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd11 || rf_wr_data !== 32'h200 || rf_wr_tag !== 4'd4)
         begin n_err++; $display("FAIL st_head1 got en=%b addr=%0d data=%h tag=%0d exp 1/11/200/4", rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_tag); end
      n_vec++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL st_stall_fall got %b exp 0", stall_wb); end
      tick();
      n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL st_drained got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_flush();
      idle();
      a_wr(5'd2, 32'hC0); b_push(4'd6, 5'd12, 32'h300);
      tick();
      a_wr(5'd2, 32'hC1); b_push(4'd7, 5'd13, 32'h400);
      tick();
      mdu_valid = 0; a_wr(5'd2, 32'hC2); mdu_flush = 1;
      n_vec++; if (mdu_ready !== 1'b0) begin n_err++; $display("FAIL fl_full got %b exp 0", mdu_ready); end
      tick();
      mdu_flush = 0; a_wr(5'd2, 32'hC3);
      n_vec++; if (clr_dirty_en !== 1'b0 || rf_wr_data !== 32'hC2) begin n_err++; $display("FAIL fl_c2 got clr=%b data=%h exp 0/c2", clr_dirty_en, rf_wr_data); end
      tick();
      a_wr(5'd2, 32'hC4);
      n_vec++; if (clr_dirty_en !== 1'b1 || clr_dirty_addr !== 5'd12) begin n_err++; $display("FAIL fl_clr0 got en=%b addr=%0d exp 1/12", clr_dirty_en, clr_dirty_addr); end
      n_vec++; if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'hC3) begin n_err++; $display("FAIL fl_a3 got en=%b data=%h exp 1/c3", rf_wr_en, rf_wr_data); end
      tick();
      idle();
      n_vec++; if (clr_dirty_en !== 1'b1 || clr_dirty_addr !== 5'd13) begin n_err++; $display("FAIL fl_clr1 got en=%b addr=%0d exp 1/13", clr_dirty_en, clr_dirty_addr); end
      n_vec++; if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'hC4) begin n_err++; $display("FAIL fl_a4 got en=%b data=%h exp 1/c4", rf_wr_en, rf_wr_data); end
      tick();
      n_vec++; if (clr_dirty_en !== 1'b0 || rf_wr_en !== 1'b0 || mdu_ready !== 1'b1)
         begin n_err++; $display("FAIL fl_end got clr=%b wr=%b rdy=%b exp 0/0/1", clr_dirty_en, rf_wr_en, mdu_ready); end
   endtask

   task automatic test_push_flush();
      idle();
      b_push(4'd5, 5'd20, 32'h55); mdu_flush = 1;
      wb_clr_en = 1; wb_wr_addr = 5'd3;
      tick();
      mdu_valid = 0; mdu_flush = 0; wb_wr_addr = 5'd4;
      n_vec++; if (clr_dirty_en !== 1'b1 || clr_dirty_addr !== 5'd3 || rf_wr_en !== 1'b0)
         begin n_err++; $display("FAIL pf_a3 got clr=%b addr=%0d wr=%b exp 1/3/0", clr_dirty_en, clr_dirty_addr, rf_wr_en); end
      tick();
      idle();
      n_vec++; if (clr_dirty_en !== 1'b1 || clr_dirty_addr !== 5'd4 || rf_wr_en !== 1'b0)
         begin n_err++; $display("FAIL pf_a4 got clr=%b addr=%0d wr=%b exp 1/4/0", clr_dirty_en, clr_dirty_addr, rf_wr_en); end
      tick();
      n_vec++; if (clr_dirty_en !== 1'b1 || clr_dirty_addr !== 5'd20 || rf_wr_en !== 1'b0)
         begin n_err++; $display("FAIL pf_killed got clr=%b addr=%0d wr=%b exp 1/20/0", clr_dirty_en, clr_dirty_addr, rf_wr_en); end
      tick();
      n_vec++; if (clr_dirty_en !== 1'b0 || rf_wr_en !== 1'b0 || mdu_ready !== 1'b1)
         begin n_err++; $display("FAIL pf_end got clr=%b wr=%b rdy=%b exp 0/0/1", clr_dirty_en, rf_wr_en, mdu_ready); end
   endtask

   task automatic test_reset_mid();
      idle();
      a_wr(5'd3, 32'hD0); b_push(4'd8, 5'd14, 32'h500);
      tick();
      a_wr(5'd3, 32'hD1); b_push(4'd9, 5'd15, 32'h600);
      tick();
      mdu_valid = 0; a_wr(5'd3, 32'hD2);
      n_vec++; if (mdu_ready !== 1'b0 || rf_wr_en !== 1'b1) begin n_err++; $display("FAIL rm_pre got rdy=%b wr=%b exp 0/1", mdu_ready, rf_wr_en); end
      #1 reset = 1'b1;
      #1;
      n_vec++; if (rf_wr_en !== 1'b0 || rf_wr_data !== 32'h0 || clr_dirty_en !== 1'b0)
         begin n_err++; $display("FAIL rm_async got wr=%b data=%h clr=%b exp 0/0/0", rf_wr_en, rf_wr_data, clr_dirty_en); end
      n_vec++; if (mdu_ready !== 1'b1 || stall_wb !== 1'b0) begin n_err++; $display("FAIL rm_ctrl got rdy=%b stall=%b exp 1/0", mdu_ready, stall_wb); end
      idle();
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (rf_wr_en !== 1'b0 || clr_dirty_en !== 1'b0 || mdu_ready !== 1'b1)
            begin n_err++; $display("FAIL rm_stale%0d got wr=%b clr=%b rdy=%b exp 0/0/1", i, rf_wr_en, clr_dirty_en, mdu_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_a_write();
      test_b_only();
      test_starve();
      test_flush();
      test_push_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_wr_arb.md
Name: rf_wr_arb

Overview:
- Arbitrates the single register-file write port and the single dirty-clear port between two sources:
  - Source A: the WB stage, which cannot be back-pressured within a cycle.
  - Source B: the multi-cycle MUL/DIV unit, using a valid/ready handshake.
- B results are buffered in a small FIFO and drained into free port slots.
- Flushed B results are converted into dirty-clears.
- A starvation counter stalls WB so that B eventually drains.
- Sits between wb_stage/mdu and the register file/scoreboard.

Parameters:
- TAG_WIDTH, 4: width of the rename/scoreboard tag carried with each write.
- DEPTH, 2: B FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: cycles a B head may wait before stall_wb asserts; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_wr_en  in  1  A requests an RF write this cycle.
- wb_clr_en  in  1  A requests a dirty-clear this cycle (flushed WB instruction).
- wb_wr_tag  in  TAG_WIDTH  A tag.
- wb_wr_addr  in  5  A destination / clear address.
- wb_wr_data  in  32  A write data.
- stall_wb  out  1  holds WB; asserted on B starvation.
- mdu_valid  in  1  B result valid.
- mdu_ready  out  1  B result accepted when mdu_valid & mdu_ready.
- mdu_tag  in  TAG_WIDTH  B tag.
- mdu_addr  in  5  B destination.
- mdu_data  in  32  B data.
- mdu_flush  in  1  kill all B results queued or pushed this cycle.
- rf_wr_en  out  1  registered RF write strobe.
- rf_wr_tag  out  TAG_WIDTH  registered.
- rf_wr_addr  out  5  registered.
- rf_wr_data  out  32  registered.
- clr_dirty_en  out  1  registered dirty-clear strobe.
- clr_dirty_addr  out  5  registered.

Behaviour:
- Reset:
  - All registered outputs are 0; FIFO is empty (pointers and count 0); wait counter is 0.
  - Immediately after reset: mdu_ready=1, stall_wb=0.
- Latency: a granted request appears on the output ports exactly 1 cycle later. Outputs are 0 in any cycle with no grant for that port.
- Source A is always granted:
  - wb_wr_en drives the RF port; wb_clr_en drives the clr port.
  - Both strobes high in the same cycle is illegal; the bench asserts against it.
- FIFO:
  - mdu_ready = !full.
  - Push on mdu_valid & mdu_ready. A push while full is impossible; push and pop in the same cycle are allowed when not full.
  - Each entry holds {tag, addr, data, killed}.
  - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- Head pop (at most 1 per cycle):
  - Live head pops when wb_wr_en=0 and drives the RF port.
  - Killed head pops when wb_clr_en=0 and drives the clr port.
  - A write and a B clear may therefore go out in the same cycle (and vice versa).
- mdu_flush:
  - Sets killed on every valid entry.
  - An entry pushed in the same cycle is stored killed.
  - If the head pops in the flush cycle it is still issued per its pre-flush killed state.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_wb = (cnt == STARVE_LIMIT), combinational from the counter.
- Stall contract: WB issues no request in the cycle after stall_wb is seen. The head then pops, the counter clears, and stall_wb drops the following cycle.
  - If WB violates the contract, A still wins and nothing is lost; stall_wb stays high.
- Reset mid-operation: all FIFO entries are discarded. Flushing the scoreboard is the pipeline's responsibility.

Test Plan:
- Idle B, A write: wb_wr_en=1, addr=5, data=0x1234, tag=3 → next cycle rf_wr_en=1, addr 5, data 0x1234, tag 3, clr_dirty_en=0.
- B only, no A traffic: push {tag 1, addr 7, data 0xAA} → rf_wr_en=1 with addr 7, data 0xAA two cycles after the push edge; mdu_ready stays 1.
- A write every cycle, B pushes 2 entries (DEPTH=2):
  - mdu_ready=0 once full.
  - stall_wb rises after 4 waiting cycles.
  - With WB honoring the stall, B head writes, then stall_wb falls and the counter restarts for the second entry.
- Queue 2 entries, pulse mdu_flush with A writing continuously → both entries emerge on clr_dirty_en (addrs in order) in consecutive cycles alongside the A writes; rf_wr_en never carries B data.
- Same-cycle push + flush, then A clr active → new entry is stored killed and waits until wb_clr_en=0, then appears as a clear.
- Assert reset with 2 queued entries → all outputs 0 immediately; after release, FIFO is empty, mdu_ready=1, and no stale write appears.
